axis_packet_buffer: RTL
=======================

# axis_packet_buffer

Downstream AXI-stream sink that accepts byte beats from the stream data-generation master and stores one packet at a time in a local byte memory. It receives `s_tdata` beats until `s_tlast`, then stops accepting data and presents the stored packet to a consumer through a registered random-read port. It reports the packet length, an overflow flag and an optional checksum. The consumer releases the buffer with a one-cycle acknowledge.

## Interface
Parameters:
- `DEPTH`, 16, buffer capacity in bytes (power of two, ≥2)
- `AW`, 4, address width, log2(`DEPTH`)

Ports:
- `clk` in 1: sole clock; all logic on rising edge
- `resetn` in 1: synchronous, active-low reset
- `s_tvalid` in 1: upstream beat valid
- `s_tdata` in 8: upstream beat data
- `s_tlast` in 1: last beat of packet
- `s_tready` out 1: registered; buffer can accept a beat
- `pkt_valid` out 1: a complete packet is held
- `pkt_len` out AW+1: stored byte count, 1..`DEPTH`
- `pkt_err` out 1: packet exceeded `DEPTH`; excess bytes dropped
- `pkt_sum` out 8: mod-256 sum of stored bytes
- `pkt_ack` in 1: consumer releases the held packet
- `rd_addr` in AW: read address
- `rd_data` out 8: registered read data

## Operation
- A beat is accepted when `s_tvalid & s_tready` at a rising edge. A beat offered while `s_tready`=0 is ignored, and upstream must hold it.
- Reset values:
  - `s_tready`=1
  - `pkt_valid`=0, `pkt_len`=0, `pkt_err`=0, `pkt_sum`=0
  - `rd_data`=0
  - write pointer=0
  - state=RECV
  - Memory contents are not reset.
- State RECV (`s_tready`=1), on an accepted beat:
  - `mem[wr_ptr]`←`s_tdata`, `wr_ptr`+1, running sum += `s_tdata`.
  - If `s_tlast`: go to HOLD. `pkt_len`←`wr_ptr`+1, `pkt_valid`←1.
  - Else if `wr_ptr`==`DEPTH`-1: go to DROP. `pkt_err`←1.
- State DROP (`s_tready`=1):
  - Accepted beats are discarded; memory, sum and pointer are unchanged.
  - On an accepted beat with `s_tlast`: go to HOLD. `pkt_len`←`DEPTH`, `pkt_valid`←1.
- State HOLD (`s_tready`=0):
  - `pkt_len`, `pkt_err` and `pkt_sum` are stable.
  - On `pkt_ack`=1: `pkt_valid`←0, `pkt_err`←0, pointer←0, running sum←0, go to RECV.
  - `pkt_len` and `pkt_sum` keep their values until the next packet completes.
- `pkt_ack` outside HOLD is ignored.
- A `DEPTH`-byte packet with `s_tlast` on byte `DEPTH` completes normally (`pkt_err`=0).
- Reset asserted mid-packet discards the partial packet. The next packet is stored from address 0.
- Arithmetic:
  - `pkt_sum` wraps mod 256.
  - The pointer is AW+1 bits and never exceeds `DEPTH`.

## Timing
- `s_tready` is registered and reflects the next state. The beat carrying `s_tlast` is the last one accepted; `s_tready`=0 from the following cycle.
- `pkt_valid` rises in the cycle after the `s_tlast` beat is accepted.
- `pkt_ack` is sampled in cycle N:
  - `pkt_valid`=0 and `s_tready`=1 from cycle N+1.
  - The first new beat can be accepted at the N+1 edge.
- Read port:
  - `rd_data` = `mem[rd_addr]` sampled at the previous edge (1-cycle latency).
  - It updates every cycle in every state.
  - Reading a location written on the same edge returns the old contents.
- `s_tvalid` gaps are allowed in RECV and DROP; the pointer advances only on accepted beats.

## Configuration
- `AXIS_PKT_CHECKSUM_EN` defined: the running sum and `pkt_sum` operate as described.
- Undefined: no sum logic is built, and `pkt_sum` is tied to 0. All other behaviour is unchanged.

## Test plan
- Reset, then 8 beats 16,17,29,31,59,60,65,30 with `s_tlast` on 30 → `pkt_valid`=1, `pkt_len`=8, `pkt_err`=0, `pkt_sum`=0x33. `rd_addr` 0..7 returns the same bytes one cycle later.
- Upstream holds `s_tvalid`=1 during HOLD → `s_tready`=0 and no writes. `pkt_ack` in cycle N → the next packet's first byte is stored at address 0 at the N+1 edge.
- `DEPTH`=16, 20-beat packet with bytes 1..20 → `pkt_err`=1, `pkt_len`=16, memory holds 1..16, `pkt_sum`=136 (0x88).
- Exactly 16 beats with `s_tlast` on the 16th → `pkt_err`=0, `pkt_len`=16. A single-beat packet 0xA5 → `pkt_len`=1, `pkt_sum`=0xA5.
- `resetn` low for one cycle after 3 beats → all outputs at reset values, `s_tready`=1. A following 2-beat packet gives `pkt_len`=2.
- Build without `AXIS_PKT_CHECKSUM_EN`, repeat the first scenario → `pkt_sum`=0, all else identical.

Source files
------------

// File: rtl/axis_packet_buffer.sv
// Single-packet AXI-stream byte buffer with a registered random-read port.
// Define AXIS_PKT_CHECKSUM_EN to build the running mod-256 checksum; otherwise pkt_sum is tied to 0.
module axis_packet_buffer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          s_tvalid,
  input  logic [7:0]    s_tdata,
  input  logic          s_tlast,
  output logic          s_tready,
  output logic          pkt_valid,
  output logic [AW:0]   pkt_len,
  output logic          pkt_err,
  output logic [7:0]    pkt_sum,
  input  logic          pkt_ack,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  typedef enum logic [1:0] {RECV, DROP, HOLD} state_t;

  localparam logic [AW:0] LAST_IDX = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] FULL_LEN = (AW+1)'(DEPTH);

  state_t      state;
  logic [AW:0] wr_ptr;
  logic [7:0]  mem [DEPTH];
  logic        acc;

  assign acc = s_tvalid & s_tready;

  always_ff @(posedge clk) begin
    if (acc && state == RECV)
      mem[wr_ptr[AW-1:0]] <= s_tdata;
  end

  // s_tready is registered as "next state is not HOLD"
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= RECV;
      s_tready  <= 1'b1;
      pkt_valid <= 1'b0;
      pkt_len   <= '0;
      pkt_err   <= 1'b0;
      wr_ptr    <= '0;
      rd_data   <= '0;
    end else begin
      rd_data <= mem[rd_addr];
      case (state)
        RECV: begin
          if (acc) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (s_tlast) begin
              state     <= HOLD;
              s_tready  <= 1'b0;
              pkt_len   <= wr_ptr + 1'b1;
              pkt_valid <= 1'b1;
            end else if (wr_ptr == LAST_IDX) begin
              state   <= DROP;
              pkt_err <= 1'b1;
            end
          end
        end
        DROP: begin
          if (acc && s_tlast) begin
            state     <= HOLD;
            s_tready  <= 1'b0;
            pkt_len   <= FULL_LEN;
            pkt_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (pkt_ack) begin
            state     <= RECV;
            s_tready  <= 1'b1;
            pkt_valid <= 1'b0;
            pkt_err   <= 1'b0;
            wr_ptr    <= '0;
          end
        end
        default: state <= RECV;
      endcase
    end
  end

`ifdef AXIS_PKT_CHECKSUM_EN
  logic [7:0] sum_q;
  logic [7:0] pkt_sum_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sum_q     <= '0;
      pkt_sum_q <= '0;
    end else if (state == RECV && acc) begin
      sum_q <= sum_q + s_tdata;
      if (s_tlast)
        pkt_sum_q <= sum_q + s_tdata;
    end else if (state == DROP && acc && s_tlast) begin
      pkt_sum_q <= sum_q;
    end else if (state == HOLD && pkt_ack) begin
      sum_q <= '0;
    end
  end

  assign pkt_sum = pkt_sum_q;
`else
  assign pkt_sum = '0;
`endif

endmodule
